// File: rtl/circ_buf_self_trig.sv
// circ_buf_self_trig
// Self-trigger discriminator placed in front of the circular-buffer-to-DDR3
// mover. Watches ADC sample pairs as they enter the circular buffer, detects
// threshold crossings with hysteresis re-arm and holdoff, pushes the buffer
// write address of each trigger into the trigger-address FIFO and latches a
// 42-bit time stamp ({41-bit time counter, index of first crossing sample}).
//
// Build option: define CIRC_BUF_SELFTRIG_DROP_CNT_EN to build the saturating
// dropped-trigger counter; when undefined dropped_trig_cnt reads 0 and
// triggers that meet a full FIFO are silently discarded.

module circ_buf_self_trig (
   input  logic        adc_clk,
   input  logic        reset_clk_adc_n,
   input  logic        cbuf_trig_en,
   input  logic        time_clr,
   input  logic [25:0] adc_dat,
   input  logic        adc_dat_valid,
   input  logic [15:0] circ_buf_wr_addr,
   input  logic [11:0] trig_threshold,
   input  logic        trig_polarity,
   input  logic [7:0]  trig_hyst,
   input  logic [15:0] trig_holdoff,
   input  logic        trig_fifo_full,
   output logic        trig_fifo_wr_en,
   output logic [15:0] trig_fifo_wr_addr,
   output logic [41:0] trigger_time,
   output logic        trig_armed,
   output logic [15:0] dropped_trig_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_REARM,
      ST_ARMED,
      ST_HOLDOFF
   } stateT;

   stateT       r_state;
   stateT       w_nextState;

   logic [40:0] r_timeCnt;

   logic        r_s1Valid;
   logic        r_s1Over0;
   logic        r_s1Over1;
   logic        r_s1BelowRearm;
   logic        r_s1FirstIdx;
   logic [15:0] r_s1Addr;
   logic [40:0] r_s1Time;

   logic [15:0] r_holdCnt;

   logic        r_wrEn;
   logic [15:0] r_wrAddr;
   logic [41:0] r_trigTime;

   logic [11:0] w_sample0;
   logic [11:0] w_sample1;
   logic        w_unusedOverRange;
   logic [12:0] w_levelSum;
   logic [11:0] w_hystExt;
   logic [11:0] w_rearmLevel;
   logic        w_over0;
   logic        w_over1;
   logic        w_belowRearm;
   logic        w_trig;
   logic        w_write;

   assign w_sample0         = adc_dat[11:0];
   assign w_sample1         = adc_dat[23:12];
   // Over-range flags travel with the data but take no part in the decision.
   assign w_unusedOverRange = ^adc_dat[25:24];

   // Free-running time stamp counter; a clear wins over the increment.
   always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
      if (!reset_clk_adc_n) begin
         r_timeCnt <= '0;
      end else if (time_clr) begin
         r_timeCnt <= '0;
      end else begin
         r_timeCnt <= r_timeCnt + 41'd1;
      end
   end

   // Crossing tests and the saturating re-arm level for the current sample pair.
   always_comb begin
      w_hystExt    = {4'd0, trig_hyst};
      w_levelSum   = {1'b0, trig_threshold} + {5'd0, trig_hyst};
      w_rearmLevel = 12'd0;
      if (trig_polarity) begin
         w_rearmLevel = w_levelSum[12] ? 12'hFFF : w_levelSum[11:0];
      end else if (trig_threshold >= w_hystExt) begin
         w_rearmLevel = trig_threshold - w_hystExt;
      end
      if (trig_polarity) begin
         w_over0      = (w_sample0 < trig_threshold);
         w_over1      = (w_sample1 < trig_threshold);
         w_belowRearm = (w_sample0 >= w_rearmLevel) && (w_sample1 >= w_rearmLevel);
      end else begin
         w_over0      = (w_sample0 > trig_threshold);
         w_over1      = (w_sample1 > trig_threshold);
         w_belowRearm = (w_sample0 <= w_rearmLevel) && (w_sample1 <= w_rearmLevel);
      end
   end

   // Stage 1: capture the crossing flags with the address and time they belong to.
   always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
      if (!reset_clk_adc_n) begin
         r_s1Valid      <= 1'b0;
         r_s1Over0      <= 1'b0;
         r_s1Over1      <= 1'b0;
         r_s1BelowRearm <= 1'b0;
         r_s1FirstIdx   <= 1'b0;
         r_s1Addr       <= '0;
         r_s1Time       <= '0;
      end else begin
         r_s1Valid <= adc_dat_valid;
         if (adc_dat_valid) begin
            r_s1Over0      <= w_over0;
            r_s1Over1      <= w_over1;
            r_s1BelowRearm <= w_belowRearm;
            r_s1FirstIdx   <= ~w_over0;
            r_s1Addr       <= circ_buf_wr_addr;
            r_s1Time       <= r_timeCnt;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
      if (!reset_clk_adc_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next state; only valid stage-1 words move it, disable always wins.
   always_comb begin
      w_nextState = r_state;
      if (!cbuf_trig_en) begin
         w_nextState = ST_IDLE;
      end else if (r_s1Valid) begin
         case (r_state)
            ST_IDLE: begin
               w_nextState = ST_WAIT_REARM;
            end
            ST_WAIT_REARM: begin
               if (r_s1BelowRearm) begin
                  w_nextState = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (r_s1Over0 || r_s1Over1) begin
                  w_nextState = (trig_holdoff == 16'd0) ? ST_WAIT_REARM : ST_HOLDOFF;
               end
            end
            ST_HOLDOFF: begin
               if (r_holdCnt <= 16'd1) begin
                  w_nextState = ST_WAIT_REARM;
               end
            end
            default: begin
               w_nextState = ST_IDLE;
            end
         endcase
      end
   end

   // FSM outputs: armed flag and the trigger / FIFO-write decisions.
   always_comb begin
      trig_armed = (r_state == ST_ARMED);
      w_trig     = r_s1Valid && cbuf_trig_en && (r_state == ST_ARMED) &&
                   (r_s1Over0 || r_s1Over1);
      w_write    = w_trig && !trig_fifo_full;
   end

   // Holdoff counter: loaded on a trigger, counts valid words down in HOLDOFF.
   always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
      if (!reset_clk_adc_n) begin
         r_holdCnt <= '0;
      end else if (!cbuf_trig_en) begin
         r_holdCnt <= '0;
      end else if (w_trig && (trig_holdoff != 16'd0)) begin
         r_holdCnt <= trig_holdoff;
      end else if (r_s1Valid && (r_state == ST_HOLDOFF) && (r_holdCnt != 16'd0)) begin
         r_holdCnt <= r_holdCnt - 16'd1;
      end
   end

   // FIFO write strobe, address and time stamp of the last accepted trigger.
   always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
      if (!reset_clk_adc_n) begin
         r_wrEn     <= 1'b0;
         r_wrAddr   <= '0;
         r_trigTime <= '0;
      end else begin
         r_wrEn <= w_write;
         if (w_write) begin
            r_wrAddr   <= r_s1Addr;
            r_trigTime <= {r_s1Time, r_s1FirstIdx};
         end
      end
   end

   assign trig_fifo_wr_en   = r_wrEn;
   assign trig_fifo_wr_addr = r_wrAddr;
   assign trigger_time      = r_trigTime;

`ifdef CIRC_BUF_SELFTRIG_DROP_CNT_EN
   logic [15:0] r_dropCnt;
   logic        w_drop;

   assign w_drop = w_trig && trig_fifo_full;

   // Saturating count of triggers lost because the FIFO was full.
   always_ff @(posedge adc_clk or negedge reset_clk_adc_n) begin
      if (!reset_clk_adc_n) begin
         r_dropCnt <= '0;
      end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
         r_dropCnt <= r_dropCnt + 16'd1;
      end
   end

   assign dropped_trig_cnt = r_dropCnt;
`else
   assign dropped_trig_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_circ_buf_self_trig.sv
// Testbench for circ_buf_self_trig: table-driven word sequences per threshold
// configuration plus hand-written abort and mid-pipeline reset sequences.

module tb_circ_buf_self_trig;

   logic        adc_clk;
   logic        reset_clk_adc_n;
   logic        cbuf_trig_en;
   logic        time_clr;
   logic [25:0] adc_dat;
   logic        adc_dat_valid;
   logic [15:0] circ_buf_wr_addr;
   logic [11:0] trig_threshold;
   logic        trig_polarity;
   logic [7:0]  trig_hyst;
   logic [15:0] trig_holdoff;
   logic        trig_fifo_full;
   logic        trig_fifo_wr_en;
   logic [15:0] trig_fifo_wr_addr;
   logic [41:0] trigger_time;
   logic        trig_armed;
   logic [15:0] dropped_trig_cnt;

   circ_buf_self_trig dut (
      .adc_clk           (adc_clk),
      .reset_clk_adc_n   (reset_clk_adc_n),
      .cbuf_trig_en      (cbuf_trig_en),
      .time_clr          (time_clr),
      .adc_dat           (adc_dat),
      .adc_dat_valid     (adc_dat_valid),
      .circ_buf_wr_addr  (circ_buf_wr_addr),
      .trig_threshold    (trig_threshold),
      .trig_polarity     (trig_polarity),
      .trig_hyst         (trig_hyst),
      .trig_holdoff      (trig_holdoff),
      .trig_fifo_full    (trig_fifo_full),
      .trig_fifo_wr_en   (trig_fifo_wr_en),
      .trig_fifo_wr_addr (trig_fifo_wr_addr),
      .trigger_time      (trigger_time),
      .trig_armed        (trig_armed),
      .dropped_trig_cnt  (dropped_trig_cnt)
   );

   // One row = one word presented to the DUT and what must follow from it.
   // full is the FIFO state while this word's trigger decision is made.
   typedef struct {
      logic        valid;
      logic [11:0] s0;
      logic [11:0] s1;
      logic [15:0] addr;
      logic        full;
      logic        clr;
      logic        expWr;
      logic        expDrop;
      logic        expArmed;
      logic        expIdx;
   } vecT;

   typedef struct {
      string       name;
      logic [11:0] thr;
      logic        pol;
      logic [7:0]  hyst;
      logic [15:0] hold;
      int          first;
      int          last;
   } scenT;

   vecT         rows[$];
   scenT        scens[$];
   logic [40:0] rowTime [0:127];

   int          checks;
   int          failures;
   logic [41:0] expTime;
   logic [15:0] expAddr;
   logic [15:0] expDropCnt;
   logic [40:0] tbTime;
   int          firstRow;

   // 100 MHz ADC clock.
   initial begin
      adc_clk = 1'b0;
      forever #5 adc_clk = ~adc_clk;
   end

   // Reference model of the time-stamp counter.
   always @(posedge adc_clk or negedge reset_clk_adc_n) begin
      if (!reset_clk_adc_n) begin
         tbTime <= '0;
      end else if (time_clr) begin
         tbTime <= '0;
      end else begin
         tbTime <= tbTime + 41'd1;
      end
   end

   task automatic addRow(input logic v, input logic [11:0] s0, input logic [11:0] s1,
                         input logic [15:0] a, input logic f, input logic c,
                         input logic ew, input logic ed, input logic ea, input logic ei);
      vecT r;
      r.valid = v; r.s0 = s0; r.s1 = s1; r.addr = a; r.full = f; r.clr = c;
      r.expWr = ew; r.expDrop = ed; r.expArmed = ea; r.expIdx = ei;
      rows.push_back(r);
   endtask

   task automatic addScen(input string n, input logic [11:0] thr, input logic pol,
                          input logic [7:0] hyst, input logic [15:0] hold, input int f);
      scenT s;
      s.name = n; s.thr = thr; s.pol = pol; s.hyst = hyst; s.hold = hold;
      s.first = f; s.last = rows.size() - 1;
      scens.push_back(s);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [11:0] s0, input logic [11:0] s1,
                                input logic [15:0] a);
      @(negedge adc_clk);
      adc_dat_valid    = v;
      adc_dat          = {2'b00, s1, s0};
      circ_buf_wr_addr = a;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".wr_en"},   64'(trig_fifo_wr_en),   64'd0);
      checkOutput({tag, ".wr_addr"}, 64'(trig_fifo_wr_addr), 64'd0);
      checkOutput({tag, ".time"},    64'(trigger_time),      64'd0);
      checkOutput({tag, ".armed"},   64'(trig_armed),        64'd0);
      checkOutput({tag, ".dropped"}, 64'(dropped_trig_cnt),  64'd0);
   endtask

   task automatic doReset(input logic [11:0] thr, input logic pol, input logic [7:0] hyst,
                          input logic [15:0] hold);
      @(negedge adc_clk);
      reset_clk_adc_n = 1'b0;
      adc_dat_valid   = 1'b0;
      trig_fifo_full  = 1'b0;
      time_clr        = 1'b0;
      cbuf_trig_en    = 1'b1;
      trig_threshold  = thr;
      trig_polarity   = pol;
      trig_hyst       = hyst;
      trig_holdoff    = hold;
      expTime         = '0;
      expAddr         = '0;
      expDropCnt      = '0;
      repeat (2) @(negedge adc_clk);
      reset_clk_adc_n = 1'b1;
   endtask

   // Outputs seen at a falling edge reflect the word driven two falling edges earlier.
   task automatic checkRow(input string tag, input int r);
      if (rows[r].expWr) begin
         expAddr = rows[r].addr;
         expTime = {rowTime[r], rows[r].expIdx};
      end
`ifdef CIRC_BUF_SELFTRIG_DROP_CNT_EN
      if (rows[r].expDrop && (expDropCnt != 16'hFFFF)) begin
         expDropCnt = expDropCnt + 16'd1;
      end
`endif
      checkOutput($sformatf("%s[%0d].wr_en", tag, r),   64'(trig_fifo_wr_en),   64'(rows[r].expWr));
      checkOutput($sformatf("%s[%0d].armed", tag, r),   64'(trig_armed),        64'(rows[r].expArmed));
      checkOutput($sformatf("%s[%0d].wr_addr", tag, r), 64'(trig_fifo_wr_addr), 64'(expAddr));
      checkOutput($sformatf("%s[%0d].time", tag, r),    64'(trigger_time),      64'(expTime));
      checkOutput($sformatf("%s[%0d].dropped", tag, r), 64'(dropped_trig_cnt),  64'(expDropCnt));
   endtask

   task automatic runRows(input string tag, input int first, input int last);
      for (int i = first; i <= last + 2; i++) begin
         @(negedge adc_clk);
         if (i >= first + 2) begin
            checkRow(tag, i - 2);
         end
         if (i <= last) begin
            adc_dat_valid    = rows[i].valid;
            adc_dat          = {2'b00, rows[i].s1, rows[i].s0};
            circ_buf_wr_addr = rows[i].addr;
            time_clr         = rows[i].clr;
            rowTime[i]       = tbTime;
         end else begin
            adc_dat_valid = 1'b0;
            time_clr      = 1'b0;
         end
         trig_fifo_full = ((i - 1 >= first) && (i - 1 <= last)) ? rows[i - 1].full : 1'b0;
      end
   endtask

   initial begin
      checks           = 0;
      failures         = 0;
      reset_clk_adc_n  = 1'b0;
      cbuf_trig_en     = 1'b1;
      time_clr         = 1'b0;
      adc_dat          = '0;
      adc_dat_valid    = 1'b0;
      circ_buf_wr_addr = '0;
      trig_threshold   = 12'h800;
      trig_polarity    = 1'b0;
      trig_hyst        = 8'h10;
      trig_holdoff     = 16'd0;
      trig_fifo_full   = 1'b0;
      expTime          = '0;
      expAddr          = '0;
      expDropCnt       = '0;

      // Positive polarity, thr 0x800, hyst 0x10 (re-arm at <= 0x7F0).
      firstRow = rows.size();
      addRow(1, 12'h100, 12'h100, 16'h1230, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h1231, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h900, 12'h100, 16'h1234, 0, 0, 1, 0, 0, 0);
      addRow(1, 12'h900, 12'h900, 16'h1235, 0, 0, 0, 0, 0, 0);
      addRow(0, 12'h100, 12'h100, 16'h1236, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h1237, 0, 1, 0, 0, 1, 0);
      addRow(0, 12'h900, 12'h900, 16'h1238, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h100, 12'h900, 16'h1240, 0, 0, 1, 0, 0, 1);
      addRow(1, 12'h7F0, 12'h7F0, 16'h1241, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h800, 12'h800, 16'h1242, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h801, 12'h7F0, 16'h1243, 0, 0, 1, 0, 0, 0);
      addRow(1, 12'h7F1, 12'h000, 16'h1244, 0, 0, 0, 0, 0, 0);
      addScen("pos", 12'h800, 1'b0, 8'h10, 16'd0, firstRow);

      // Negative polarity, thr 0x400, hyst 0x10 (re-arm at >= 0x410).
      firstRow = rows.size();
      addRow(1, 12'h500, 12'h500, 16'h1FFE, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h500, 12'h500, 16'h1FFF, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h500, 12'h300, 16'h2000, 0, 0, 1, 0, 0, 1);
      addRow(1, 12'h40F, 12'h500, 16'h2001, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h410, 12'h410, 16'h2002, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h3FF, 12'h3FF, 16'h2003, 0, 0, 1, 0, 0, 0);
      addRow(1, 12'hFFF, 12'h410, 16'h2004, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h400, 12'h400, 16'h2005, 0, 0, 0, 0, 1, 0);
      addScen("neg", 12'h400, 1'b1, 8'h10, 16'd0, firstRow);

      // Holdoff of 5 valid words; invalid words do not count.
      firstRow = rows.size();
      addRow(1, 12'h100, 12'h100, 16'h3000, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h3001, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h900, 12'h900, 16'h3002, 0, 0, 1, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h3003, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h900, 12'h900, 16'h3004, 0, 0, 0, 0, 0, 0);
      addRow(0, 12'h100, 12'h100, 16'h3005, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h3006, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h900, 12'h900, 16'h3007, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h3008, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h900, 12'h900, 16'h3009, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h300A, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h900, 12'h100, 16'h300B, 0, 0, 1, 0, 0, 0);
      addScen("holdoff", 12'h800, 1'b0, 8'h10, 16'd5, firstRow);

      // Full FIFO on three separated triggers, then one accepted.
      firstRow = rows.size();
      addRow(1, 12'h100, 12'h100, 16'h4000, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h4001, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h900, 12'h900, 16'h4002, 1, 0, 0, 1, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h4003, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'hA00, 12'h100, 16'h4004, 1, 0, 0, 1, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h4005, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h100, 12'hA00, 16'h4006, 1, 0, 0, 1, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h4007, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h900, 12'h100, 16'h4008, 0, 0, 1, 0, 0, 0);
      addScen("full", 12'h800, 1'b0, 8'h10, 16'd0, firstRow);

      // Re-arm level saturating at 0 (thr 0x010, hyst 0x20).
      firstRow = rows.size();
      addRow(1, 12'h000, 12'h000, 16'h5000, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h001, 12'h000, 16'h5001, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h000, 12'h001, 16'h5002, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h000, 12'h000, 16'h5003, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h011, 12'h000, 16'h5004, 0, 0, 1, 0, 0, 0);
      addScen("hyst_lo", 12'h010, 1'b0, 8'h20, 16'd0, firstRow);

      // Re-arm level saturating at 0xFFF (negative, thr 0xFF8, hyst 0x20).
      firstRow = rows.size();
      addRow(1, 12'hFFF, 12'hFFF, 16'h6000, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'hFFE, 12'hFFF, 16'h6001, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'hFFF, 12'hFFF, 16'h6002, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'hFFF, 12'hFF7, 16'h6003, 0, 0, 1, 0, 0, 1);
      addScen("hyst_hi", 12'hFF8, 1'b1, 8'h20, 16'd0, firstRow);

      // Trigger addresses 0xFFFF and 0x0000.
      firstRow = rows.size();
      addRow(1, 12'h100, 12'h100, 16'hFFFD, 0, 0, 0, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'hFFFE, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h900, 12'h100, 16'hFFFF, 0, 0, 1, 0, 0, 0);
      addRow(1, 12'h100, 12'h100, 16'h7FFF, 0, 0, 0, 0, 1, 0);
      addRow(1, 12'h900, 12'h900, 16'h0000, 0, 0, 1, 0, 0, 0);
      addScen("wrap", 12'h800, 1'b0, 8'h10, 16'd0, firstRow);

      repeat (3) @(negedge adc_clk);
      checkResetValues("por");

      foreach (scens[k]) begin
         doReset(scens[k].thr, scens[k].pol, scens[k].hyst, scens[k].hold);
         runRows(scens[k].name, scens[k].first, scens[k].last);
      end

      // Disable during HOLDOFF must return to IDLE and clear the holdoff count.
      doReset(12'h800, 1'b0, 8'h10, 16'd5);
      applyStimulus(1, 12'h100, 12'h100, 16'h0A00);
      applyStimulus(1, 12'h100, 12'h100, 16'h0A01);
      applyStimulus(1, 12'h900, 12'h900, 16'h0AAA);
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      checkOutput("abort.wr_en", 64'(trig_fifo_wr_en), 64'd1);
      checkOutput("abort.wr_addr", 64'(trig_fifo_wr_addr), 64'h0AAA);
      cbuf_trig_en = 1'b0;
      applyStimulus(1, 12'h100, 12'h100, 16'h0A03);
      checkOutput("abort.armed_off", 64'(trig_armed), 64'd0);
      cbuf_trig_en = 1'b1;
      applyStimulus(1, 12'h100, 12'h100, 16'h0A04);
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      checkOutput("abort.armed_wait", 64'(trig_armed), 64'd0);
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      checkOutput("abort.rearmed", 64'(trig_armed), 64'd1);
      cbuf_trig_en = 1'b0;
      applyStimulus(1, 12'h900, 12'h900, 16'h0BBB);
      checkOutput("abort.armed_drop", 64'(trig_armed), 64'd0);
      cbuf_trig_en = 1'b1;
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      checkOutput("abort.no_wr_idle", 64'(trig_fifo_wr_en), 64'd0);
      checkOutput("abort.addr_hold", 64'(trig_fifo_wr_addr), 64'h0AAA);

      // Reset while a trigger sits in stage 1 discards it.
      doReset(12'h800, 1'b0, 8'h10, 16'd0);
      applyStimulus(1, 12'h100, 12'h100, 16'h0C00);
      applyStimulus(1, 12'h100, 12'h100, 16'h0C01);
      applyStimulus(1, 12'h900, 12'h100, 16'h5555);
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      applyStimulus(0, 12'h000, 12'h000, 16'h0000);
      checkOutput("midrst.pre_wr_en", 64'(trig_fifo_wr_en), 64'd1);
      checkOutput("midrst.pre_addr", 64'(trig_fifo_wr_addr), 64'h5555);
      applyStimulus(1, 12'h100, 12'h100, 16'h0C05);
      applyStimulus(1, 12'h900, 12'h900, 16'h6666);
      @(posedge adc_clk);
      #2;
      reset_clk_adc_n = 1'b0;
      adc_dat_valid   = 1'b0;
      #1;
      checkResetValues("midrst");
      repeat (2) @(negedge adc_clk);
      reset_clk_adc_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge adc_clk);
         checkOutput($sformatf("midrst.no_wr[%0d]", n), 64'(trig_fifo_wr_en), 64'd0);
      end
      checkOutput("midrst.addr", 64'(trig_fifo_wr_addr), 64'd0);
      checkOutput("midrst.time", 64'(trigger_time), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
